darkcore_mt: RTL and testbench

Multi-threaded successor of the single-thread execute/writeback datapath: decodes and executes one RV32I instruction per en_al/en_wb handshake pair while holding THREADS independent architectural register banks selected by a per-instruction thread id. It sits between the fetch/thread scheduler, which supplies pc, inst and tid, and the data-memory bus, which receives addr_al, data_al and be_al and returns data_wb. It adds byte enables, misalignment detection and an optional MAC instruction.

---
 rtl/darkcore_pkg.sv | 29 ++
 rtl/darkcore_mt_if.sv | 29 ++
 rtl/darkcore_lsu_align.sv | 58 +++++
 rtl/darkcore_mt.sv | 209 ++++++++++++++++++++
 tb/tb_darkcore_mt.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/darkcore_pkg.sv
// darkcore_pkg: shared opcodes, load/store width codes and FSM state type for darkcore_mt.
package darkcore_pkg;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BCC   = 7'b1100011;
   localparam logic [6:0] OP_LCC   = 7'b0000011;
   localparam logic [6:0] OP_SCC   = 7'b0100011;
   localparam logic [6:0] OP_MCC   = 7'b0010011;
   localparam logic [6:0] OP_RCC   = 7'b0110011;
   localparam logic [6:0] OP_FCC   = 7'b0001111;
   localparam logic [6:0] OP_CCC   = 7'b1110011;
   localparam logic [6:0] OP_MAC   = 7'b1111111;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, ALU, WRB} state_t;

   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

endpackage

// File: rtl/darkcore_mt_if.sv
// darkcore_mt_if: scheduler and data-bus signal bundle of darkcore_mt.
interface darkcore_mt_if #(
   parameter int TW = 1
);
   logic          en_al;
   logic          en_wb;
   logic [TW-1:0] tid;
   logic [31:0]   pc;
   logic [31:0]   inst;
   logic [31:0]   data_wb;
   logic          valid_al;
   logic [31:0]   addr_al;
   logic [31:0]   data_al;
   logic [3:0]    be_al;
   logic          we_al;
   logic          misal;
   logic          valid_wb;
   logic [31:0]   nxpc;

   modport slave (
      input  en_al, en_wb, tid, pc, inst, data_wb,
      output valid_al, addr_al, data_al, be_al, we_al, misal, valid_wb, nxpc
   );

   modport master (
      output en_al, en_wb, tid, pc, inst, data_wb,
      input  valid_al, addr_al, data_al, be_al, we_al, misal, valid_wb, nxpc
   );
endinterface

// File: rtl/darkcore_lsu_align.sv
// darkcore_lsu_align: store lane shift, byte enables, misalignment and load extraction.
module darkcore_lsu_align
   import darkcore_pkg::*;
(
   input  logic [1:0]  i_st_addr,
   input  logic [2:0]  i_st_f3,
   input  logic        i_is_mem,
   input  logic [31:0] i_st_data,
   input  logic [1:0]  i_ld_addr,
   input  logic [2:0]  i_ld_f3,
   input  logic [31:0] i_ld_raw,
   output logic [31:0] o_st_data,
   output logic [3:0]  o_be,
   output logic        o_misal,
   output logic [31:0] o_ld_data
);
   logic [3:0]  w_be;
   logic        w_misal;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_be      = 4'b1111;
      w_misal   = 1'b0;
      o_st_data = i_st_data;
      case (i_st_f3)
         F3_B, F3_BU: begin
            w_be      = 4'b0001 << i_st_addr;
            o_st_data = i_st_data << {i_st_addr, 3'b000};
         end
         F3_H, F3_HU: begin
            w_misal   = i_st_addr[0];
            w_be      = 4'b0011 << {i_st_addr[1], 1'b0};
            o_st_data = i_st_data << {i_st_addr[1], 4'b0000};
         end
         default: w_misal = |i_st_addr;
      endcase
   end

   // A misaligned access must not touch memory, so its lanes are all disabled.
   assign o_misal = i_is_mem & w_misal;
   assign o_be    = (i_is_mem && !w_misal) ? w_be : 4'b0000;

   assign w_byte = i_ld_raw[{i_ld_addr, 3'b000} +: 8];
   assign w_half = i_ld_raw[{i_ld_addr[1], 4'b0000} +: 16];

   always_comb begin
      o_ld_data = i_ld_raw;
      case (i_ld_f3)
         F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_ld_data = {24'd0, w_byte};
         F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
         F3_HU:   o_ld_data = {16'd0, w_half};
         F3_W:    o_ld_data = i_ld_raw;
         default: o_ld_data = i_ld_raw;
      endcase
   end
endmodule

// File: rtl/darkcore_mt.sv
// darkcore_mt: multi-threaded RV32I execute/writeback datapath with one register bank per thread.
// Define DARKCORE_MAC_EN to enable the signed 16x16 multiply-accumulate opcode 1111111.
module darkcore_mt
   import darkcore_pkg::*;
#(
   parameter int THREADS = 2,
   parameter int CORE_ID = 0
)(
   input  logic         clk,
   input  logic         res,
   darkcore_mt_if.slave bus
);
   localparam int TW    = (THREADS > 1) ? $clog2(THREADS) : 1;
   localparam int DEPTH = 32 << TW;
`ifdef DARKCORE_MAC_EN
   localparam bit MAC_EN = 1'b1;
   localparam int NRP    = 3;
`else
   localparam bit MAC_EN = 1'b0;
   localparam int NRP    = 2;
`endif

   state_t      r_state, w_state_next;
   logic [31:0] r_regs [DEPTH];
   logic [31:0] r_addr, r_data, r_alu;
   logic [3:0]  r_be;
   logic        r_we, r_misal, r_is_load, r_wr_ok;
   logic [4:0]  r_rd;
   logic [2:0]  r_f3;

   logic [TW-1:0] w_tid;
   logic [31:0]   w_inst, w_pc, w_x4;
   logic [6:0]    w_op;
   logic [4:0]    w_rd, w_rs1i, w_rs2i;
   logic [2:0]    w_f3;
   logic [31:0]   w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
   logic [4:0]    w_ridx [NRP];
   logic [31:0]   w_rval [NRP];
   logic [31:0]   w_rs1, w_rs2, w_opb, w_addr, w_arith, w_alu, w_nxpc;
   logic          w_is_mem, w_taken, w_op_wr, w_wr_en;
   logic [31:0]   w_st_data, w_ld_data, w_wb_data;
   logic [3:0]    w_be;
   logic          w_misal;

   assign w_tid  = bus.tid;
   assign w_inst = bus.inst;
   assign w_pc   = bus.pc;
   assign w_op   = w_inst[6:0];
   assign w_rd   = w_inst[11:7];
   assign w_f3   = w_inst[14:12];
   assign w_rs1i = w_inst[19:15];
   assign w_rs2i = w_inst[24:20];

   assign w_imm_i = sext12(w_inst[31:20]);
   assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
   assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
   assign w_imm_u = {w_inst[31:12], 12'd0};
   assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

   // x4 is a per-thread hart id, never backed by storage.
   assign w_x4 = 32'(CORE_ID * THREADS) + 32'(w_tid);

   assign w_ridx[0] = w_rs1i;
   assign w_ridx[1] = w_rs2i;
`ifdef DARKCORE_MAC_EN
   assign w_ridx[2] = w_rd;
`endif

   for (genvar gi = 0; gi < NRP; gi++) begin : g_rport
      assign w_rval[gi] = (w_ridx[gi] == 5'd0) ? 32'd0 :
                          (w_ridx[gi] == 5'd4) ? w_x4  : r_regs[{w_tid, w_ridx[gi]}];
   end

   assign w_rs1    = w_rval[0];
   assign w_rs2    = w_rval[1];
   assign w_opb    = (w_op == OP_RCC) ? w_rs2 : w_imm_i;
   assign w_addr   = w_rs1 + ((w_op == OP_SCC) ? w_imm_s : w_imm_i);
   assign w_is_mem = (w_op == OP_LCC) || (w_op == OP_SCC);

   always_comb begin
      w_arith = '0;
      case (w_f3)
         3'b000:  w_arith = (w_op == OP_RCC && w_inst[30]) ? w_rs1 - w_opb : w_rs1 + w_opb;
         3'b001:  w_arith = w_rs1 << w_opb[4:0];
         3'b010:  w_arith = {31'd0, $signed(w_rs1) < $signed(w_opb)};
         3'b011:  w_arith = {31'd0, w_rs1 < w_opb};
         3'b100:  w_arith = w_rs1 ^ w_opb;
         3'b101:  w_arith = w_inst[30] ? 32'($signed(w_rs1) >>> w_opb[4:0]) : w_rs1 >> w_opb[4:0];
         3'b110:  w_arith = w_rs1 | w_opb;
         default: w_arith = w_rs1 & w_opb;
      endcase
   end

`ifdef DARKCORE_MAC_EN
   logic signed [31:0] w_prod;
   logic [31:0]        w_mac;
   assign w_prod = $signed(w_rs1[15:0]) * $signed(w_rs2[15:0]);
   assign w_mac  = w_rval[2] + w_prod;
`endif

   always_comb begin
      w_alu = '0;
      case (w_op)
         OP_LUI:           w_alu = w_imm_u;
         OP_AUIPC:         w_alu = w_pc + w_imm_u;
         OP_JAL, OP_JALR:  w_alu = w_pc + 32'd4;
         OP_MCC, OP_RCC:   w_alu = w_arith;
`ifdef DARKCORE_MAC_EN
         OP_MAC:           w_alu = w_mac;
`endif
         default:          w_alu = '0;
      endcase
   end

   always_comb begin
      w_taken = 1'b0;
      case (w_f3)
         3'b000:  w_taken = (w_rs1 == w_rs2);
         3'b001:  w_taken = (w_rs1 != w_rs2);
         3'b100:  w_taken = ($signed(w_rs1) <  $signed(w_rs2));
         3'b101:  w_taken = ($signed(w_rs1) >= $signed(w_rs2));
         3'b110:  w_taken = (w_rs1 <  w_rs2);
         3'b111:  w_taken = (w_rs1 >= w_rs2);
         default: w_taken = 1'b0;
      endcase
   end

   always_comb begin
      w_nxpc = w_pc + 32'd4;
      if (w_op == OP_BCC && w_taken) w_nxpc = w_pc + w_imm_b;
      else if (w_op == OP_JAL)       w_nxpc = w_pc + w_imm_j;
      else if (w_op == OP_JALR)      w_nxpc = w_addr & 32'hFFFF_FFFE;
   end

   always_comb begin
      w_op_wr = 1'b0;
      case (w_op)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_MCC, OP_RCC: w_op_wr = 1'b1;
         OP_LCC:                           w_op_wr = !w_misal;
         OP_MAC:                           w_op_wr = MAC_EN;
         OP_BCC, OP_SCC, OP_FCC, OP_CCC:   w_op_wr = 1'b0;
         default:                          w_op_wr = 1'b0;
      endcase
   end

   darkcore_lsu_align u_lsu (
      .i_st_addr (w_addr[1:0]),
      .i_st_f3   (w_f3),
      .i_is_mem  (w_is_mem),
      .i_st_data (w_rs2),
      .i_ld_addr (r_addr[1:0]),
      .i_ld_f3   (r_f3),
      .i_ld_raw  (bus.data_wb),
      .o_st_data (w_st_data),
      .o_be      (w_be),
      .o_misal   (w_misal),
      .o_ld_data (w_ld_data)
   );

   // en_al wins over en_wb, which silently drops a same-cycle writeback.
   always_comb begin
      w_state_next = IDLE;
      if (bus.en_al)      w_state_next = ALU;
      else if (bus.en_wb) w_state_next = WRB;
      w_wr_en   = (w_state_next == WRB) && r_wr_ok;
      w_wb_data = r_is_load ? w_ld_data : r_alu;
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_state   <= IDLE;
         r_addr    <= '0;
         r_data    <= '0;
         r_alu     <= '0;
         r_be      <= '0;
         r_we      <= 1'b0;
         r_misal   <= 1'b0;
         r_is_load <= 1'b0;
         r_wr_ok   <= 1'b0;
         r_rd      <= '0;
         r_f3      <= '0;
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_state_next == ALU) begin
            r_addr    <= w_addr;
            r_data    <= w_st_data;
            r_alu     <= w_alu;
            r_be      <= w_be;
            r_we      <= (w_op == OP_SCC);
            r_misal   <= w_misal;
            r_is_load <= (w_op == OP_LCC);
            r_wr_ok   <= w_op_wr && (w_rd != 5'd0) && (w_rd != 5'd4);
            r_rd      <= w_rd;
            r_f3      <= w_f3;
         end
         if (w_wr_en) r_regs[{w_tid, r_rd}] <= w_wb_data;
      end
   end

   assign bus.valid_al = (r_state == ALU);
   assign bus.valid_wb = (r_state == WRB);
   assign bus.addr_al  = r_addr;
   assign bus.data_al  = r_data;
   assign bus.be_al    = r_be;
   assign bus.we_al    = r_we;
   assign bus.misal    = r_misal;
   assign bus.nxpc     = w_nxpc;
endmodule

// File: tb/tb_darkcore_mt.sv
// tb_darkcore_mt: scoreboard bench for darkcore_mt with THREADS=4, CORE_ID=2.
module tb_darkcore_mt;
   localparam logic [6:0] T_LUI  = 7'b0110111;
   localparam logic [6:0] T_OPI  = 7'b0010011;
   localparam logic [6:0] T_OPR  = 7'b0110011;
   localparam logic [6:0] T_LD   = 7'b0000011;
   localparam logic [6:0] T_JALR = 7'b1100111;
   localparam logic [6:0] T_MAC  = 7'b1111111;

   typedef struct {
      string       name;
      logic [2:0]  mask;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic        we;
      logic        mis;
   } al_t;

   logic clk = 1'b0;
   logic res = 1'b1;
   int   checks = 0;
   int   failures = 0;
   al_t   al_q[$];
   string wb_q[$];
   al_t   mon_e;

   darkcore_mt_if #(.TW(2)) bus ();

   darkcore_mt #(.THREADS(4), .CORE_ID(2)) dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%08h expected=%08h", n, act, exp);
      end else
         $display("ok   %s = %08h", n, act);
   endtask

   function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                         input logic [2:0] f3, input logic [4:0] rs1,
                                         input logic [11:0] imm);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [11:0] imm);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [12:0] imm);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] op, input logic [4:0] rd,
                                         input logic [2:0] f3, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [6:0] f7);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   // mask bit0 = check addr, bit1 = check data, bit2 = check be; we/misal always checked
   task automatic issue(input string name, input logic [1:0] tid, input logic [31:0] inst,
                        input logic [31:0] dwb, input logic [2:0] mask, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be, input logic we,
                        input logic mis);
      al_t e;
      e.name = name; e.mask = mask; e.addr = addr; e.data = data;
      e.be = be; e.we = we; e.mis = mis;
      al_q.push_back(e);
      wb_q.push_back(name);
      @(negedge clk);
      bus.tid = tid; bus.pc = 32'h0; bus.inst = inst; bus.en_al = 1'b1; bus.en_wb = 1'b0;
      @(negedge clk);
      bus.en_al = 1'b0; bus.en_wb = 1'b1; bus.data_wb = dwb;
      @(negedge clk);
      bus.en_wb = 1'b0;
   endtask

   task automatic addi(input string name, input logic [1:0] tid, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [11:0] imm, input logic [31:0] addr);
      issue(name, tid, enc_i(T_OPI, rd, 3'b000, rs1, imm), 32'h0, 3'b001, addr, 32'h0, 4'h0, 1'b0, 1'b0);
   endtask

   // Register value is observed as SW rN,0(x0) store data.
   task automatic rb(input string name, input logic [1:0] tid, input logic [4:0] r,
                     input logic [31:0] exp);
      issue(name, tid, enc_s(3'b010, 5'd0, r, 12'd0), 32'h0, 3'b111, 32'h0, exp, 4'hF, 1'b1, 1'b0);
   endtask

   task automatic chk_nxpc(input string name, input logic [1:0] tid, input logic [31:0] pc,
                           input logic [31:0] inst, input logic [31:0] exp);
      @(negedge clk);
      bus.tid = tid; bus.pc = pc; bus.inst = inst;
      #1 chk(name, bus.nxpc, exp);
   endtask

   always @(negedge clk) begin
      if (res) begin
         if (bus.valid_al) begin
            if (al_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_valid_al actual=1 expected=0");
            end else begin
               mon_e = al_q.pop_front();
               if (mon_e.mask[0]) chk({mon_e.name, "_addr"}, bus.addr_al, mon_e.addr);
               if (mon_e.mask[1]) chk({mon_e.name, "_data"}, bus.data_al, mon_e.data);
               if (mon_e.mask[2]) chk({mon_e.name, "_be"}, 32'(bus.be_al), 32'(mon_e.be));
               chk({mon_e.name, "_we"}, 32'(bus.we_al), 32'(mon_e.we));
               chk({mon_e.name, "_misal"}, 32'(bus.misal), 32'(mon_e.mis));
            end
         end
         if (bus.valid_wb) begin
            if (wb_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_valid_wb actual=1 expected=0");
            end else
               void'(wb_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.en_al = 1'b0; bus.en_wb = 1'b0; bus.tid = 2'd0;
      bus.pc = 32'h0; bus.inst = 32'h0; bus.data_wb = 32'h0;
      #2 res = 1'b0;
      #1;
      chk("rst_valid_al", 32'(bus.valid_al), 32'h0);
      chk("rst_valid_wb", 32'(bus.valid_wb), 32'h0);
      chk("rst_addr_al", bus.addr_al, 32'h0);
      chk("rst_data_al", bus.data_al, 32'h0);
      chk("rst_be_al", 32'(bus.be_al), 32'h0);
      chk("rst_we_al", 32'(bus.we_al), 32'h0);
      chk("rst_misal", 32'(bus.misal), 32'h0);
      @(negedge clk) res = 1'b1;

      // Reset asserted while the writeback pulse is high.
      al_q.push_back('{name:"rst_addi", mask:3'b001, addr:32'd9, data:32'h0, be:4'h0, we:1'b0, mis:1'b0});
      @(negedge clk);
      bus.tid = 2'd0; bus.inst = enc_i(T_OPI, 5'd5, 3'b000, 5'd0, 12'd9); bus.en_al = 1'b1;
      @(negedge clk);
      bus.en_al = 1'b0; bus.en_wb = 1'b1;
      @(posedge clk);
      #1 res = 1'b0;
      #1;
      chk("midwb_valid_wb", 32'(bus.valid_wb), 32'h0);
      chk("midwb_addr_al", bus.addr_al, 32'h0);
      chk("midwb_valid_al", 32'(bus.valid_al), 32'h0);
      bus.en_wb = 1'b0;
      @(negedge clk) res = 1'b1;
      for (int t = 0; t < 4; t++) rb($sformatf("rst_x5_t%0d", t), 2'(t), 5'd5, 32'h0);

      // Thread isolation and hart id.
      addi("iso_addi", 2'd1, 5'd5, 5'd0, 12'd7, 32'd7);
      rb("iso_t1_x5", 2'd1, 5'd5, 32'd7);
      rb("iso_t0_x5", 2'd0, 5'd5, 32'd0);
      rb("iso_t2_x5", 2'd2, 5'd5, 32'd0);
      rb("iso_t3_x5", 2'd3, 5'd5, 32'd0);
      rb("x4_t3", 2'd3, 5'd4, 32'd11);
      addi("x4_write", 2'd0, 5'd4, 5'd0, 12'd1, 32'd1);
      rb("x4_t0_ro", 2'd0, 5'd4, 32'd8);

      // Store lanes.
      addi("x1_set", 2'd0, 5'd1, 5'd0, 12'h100, 32'h100);
      issue("lui_x2", 2'd0, {20'hA1B2C, 5'd2, T_LUI}, 32'h0, 3'b000, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      addi("x2_lo", 2'd0, 5'd2, 5'd2, 12'h3D4, 32'hA1B2C3D4);
      rb("x2_val", 2'd0, 5'd2, 32'hA1B2C3D4);
      issue("sb_3", 2'd0, enc_s(3'b000, 5'd1, 5'd2, 12'd3), 32'h0, 3'b111, 32'h103, 32'hD4000000, 4'b1000, 1'b1, 1'b0);
      issue("sh_2", 2'd0, enc_s(3'b001, 5'd1, 5'd2, 12'd2), 32'h0, 3'b111, 32'h102, 32'hC3D40000, 4'b1100, 1'b1, 1'b0);
      issue("sw_mis", 2'd0, enc_s(3'b010, 5'd1, 5'd2, 12'd1), 32'h0, 3'b101, 32'h101, 32'h0, 4'b0000, 1'b1, 1'b1);

      // Loads.
      issue("lh_102", 2'd0, enc_i(T_LD, 5'd6, 3'b001, 5'd1, 12'd2), 32'h80011234, 3'b001, 32'h102, 32'h0, 4'h0, 1'b0, 1'b0);
      rb("lh_x6", 2'd0, 5'd6, 32'hFFFF8001);
      issue("lhu_102", 2'd0, enc_i(T_LD, 5'd10, 3'b101, 5'd1, 12'd2), 32'h80011234, 3'b001, 32'h102, 32'h0, 4'h0, 1'b0, 1'b0);
      rb("lhu_x10", 2'd0, 5'd10, 32'h00008001);
      issue("lb_103", 2'd0, enc_i(T_LD, 5'd8, 3'b000, 5'd1, 12'd3), 32'h80011234, 3'b001, 32'h103, 32'h0, 4'h0, 1'b0, 1'b0);
      rb("lb_x8", 2'd0, 5'd8, 32'hFFFFFF80);
      addi("x7_set", 2'd0, 5'd7, 5'd0, 12'd5, 32'd5);
      issue("lw_mis", 2'd0, enc_i(T_LD, 5'd7, 3'b010, 5'd1, 12'd2), 32'h80011234, 3'b001, 32'h102, 32'h0, 4'h0, 1'b0, 1'b1);
      rb("lw_mis_x7", 2'd0, 5'd7, 32'd5);

      // ALU register forms.
      issue("sub", 2'd0, enc_r(T_OPR, 5'd11, 3'b000, 5'd1, 5'd2, 7'b0100000), 32'h0, 3'b000, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      rb("sub_x11", 2'd0, 5'd11, 32'h5E4D3D2C);
      issue("srai", 2'd0, enc_i(T_OPI, 5'd12, 3'b101, 5'd2, 12'h404), 32'h0, 3'b000, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      rb("srai_x12", 2'd0, 5'd12, 32'hFA1B2C3D);

      // en_al and en_wb together: writeback dropped.
      al_q.push_back('{name:"prio_a", mask:3'b001, addr:32'd3, data:32'h0, be:4'h0, we:1'b0, mis:1'b0});
      al_q.push_back('{name:"prio_b", mask:3'b001, addr:32'd3, data:32'h0, be:4'h0, we:1'b0, mis:1'b0});
      @(negedge clk);
      bus.tid = 2'd0; bus.pc = 32'h0; bus.inst = enc_i(T_OPI, 5'd9, 3'b000, 5'd0, 12'd3);
      bus.en_al = 1'b1; bus.en_wb = 1'b0;
      @(negedge clk);
      bus.en_wb = 1'b1;
      @(negedge clk);
      bus.en_al = 1'b0; bus.en_wb = 1'b0;
      chk("prio_valid_wb", 32'(bus.valid_wb), 32'h0);
      rb("prio_x9", 2'd0, 5'd9, 32'h0);

      // Next-pc.
      addi("t2_x1", 2'd2, 5'd1, 5'd0, 12'd1, 32'd1);
      chk_nxpc("bne_taken", 2'd2, 32'h40, enc_b(3'b001, 5'd0, 5'd1, 13'h1FF8), 32'h38);
      chk_nxpc("beq_not", 2'd2, 32'h40, enc_b(3'b000, 5'd0, 5'd1, 13'h1FF8), 32'h44);
      chk_nxpc("jal", 2'd2, 32'h40, enc_j(5'd0, 21'd16), 32'h50);
      chk_nxpc("jalr", 2'd2, 32'h40, enc_i(T_JALR, 5'd0, 3'b000, 5'd1, 12'd5), 32'h6);

      // Multiply-accumulate.
      addi("t3_x3", 2'd3, 5'd3, 5'd0, 12'd10, 32'd10);
      issue("t3_lui", 2'd3, {20'h00010, 5'd1, T_LUI}, 32'h0, 3'b000, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      addi("t3_x1", 2'd3, 5'd1, 5'd1, 12'hFFF, 32'h0000FFFF);
      addi("t3_x2", 2'd3, 5'd2, 5'd0, 12'd3, 32'd3);
      chk_nxpc("mac_nxpc", 2'd3, 32'h80, enc_r(T_MAC, 5'd3, 3'b000, 5'd1, 5'd2, 7'd0), 32'h84);
      issue("mac", 2'd3, enc_r(T_MAC, 5'd3, 3'b000, 5'd1, 5'd2, 7'd0), 32'h0, 3'b100, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
`ifdef DARKCORE_MAC_EN
      rb("mac_x3", 2'd3, 5'd3, 32'd7);
`else
      rb("mac_x3", 2'd3, 5'd3, 32'd10);
`endif

      repeat (3) @(negedge clk);
      chk("al_queue_left", 32'(al_q.size()), 32'h0);
      chk("wb_queue_left", 32'(wb_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
